cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_fifo2.sv | 52 +++++
 rtl/cdb_arbiter.sv | 108 ++++++++++
 tb/tb_cdb_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: ROB tag range, source
// count and the fixed source indices, plus the round-robin pointer helper.
package cdb_arbiter_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int CDB_NSRC  = 3;
  localparam int SRC_W     = 2;

  localparam logic [SRC_W-1:0] SRC_ALU = 2'd0;
  localparam logic [SRC_W-1:0] SRC_LSB = 2'd1;
  localparam logic [SRC_W-1:0] SRC_AUX = 2'd2;

  typedef enum logic [SRC_W-1:0] {
    SRC_E_ALU = 2'd0,
    SRC_E_LSB = 2'd1,
    SRC_E_AUX = 2'd2
  } src_e;

  // Next round-robin start index after a grant to idx, wrapping at n.
  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) begin
      return 2'd0;
    end else begin
      return idx + 2'd1;
    end
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-producer / CDB bundle. master is the arbiter side, slave is the
// side of the producers and broadcast consumers.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NSRC  = CDB_NSRC,
  parameter int TAG_W = ROB_TAG_W
);

  logic                  rdy;
  logic                  rollback;
  logic [NSRC-1:0]       src_valid;
  logic [NSRC*32-1:0]    src_result;
  logic [NSRC*TAG_W-1:0] src_tag;
  logic [NSRC-1:0]       src_ready;
  logic                  cdb_valid;
  logic [31:0]           cdb_result;
  logic [TAG_W-1:0]      cdb_tag;
  logic [SRC_W-1:0]      cdb_src;

  modport master (
    input  rdy, rollback, src_valid, src_result, src_tag,
    output src_ready, cdb_valid, cdb_result, cdb_tag, cdb_src
  );

  modport slave (
    output rdy, rollback, src_valid, src_result, src_tag,
    input  src_ready, cdb_valid, cdb_result, cdb_tag, cdb_src
  );

endinterface

// File: rtl/cdb_fifo2.sv
// Two-entry FIFO for one result producer. Push/pop qualification is done by
// the caller; clr empties the FIFO synchronously (misprediction flush).
module cdb_fifo2 #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_r;
  logic         rd_r;
  logic [1:0]   count_r;

  assign dout  = mem_r[rd_r];
  assign count = count_r;

  // Storage, read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_r     <= 1'b0;
      rd_r     <= 1'b0;
      count_r  <= 2'd0;
    end else if (clr) begin
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_r] <= din;
        wr_r        <= ~wr_r;
      end
      if (pop) begin
        rd_r <= ~rd_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one 2-entry FIFO per producer, round-robin grant
// among non-empty FIFOs, registered single-cycle broadcast per grant.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NSRC  = CDB_NSRC,
  parameter int TAG_W = ROB_TAG_W
) (
  input logic           clk,
  input logic           rst,
  cdb_arbiter_if.master bus
);

  localparam int EW = 32 + TAG_W;

  logic [EW-1:0]    head_s [NSRC];
  logic [1:0]       count_s [NSRC];
  logic [NSRC-1:0]  ready_s;
  logic [NSRC-1:0]  nonempty_s;
  logic [NSRC-1:0]  push_s;
  logic [NSRC-1:0]  pop_s;
  logic             advance_s;
  logic             clr_s;
  logic             grant_s;
  logic [SRC_W-1:0] win_s;
  logic [EW-1:0]    win_head_s;
  logic [SRC_W-1:0] ptr_r;

  // Pipeline moves only when rdy is high and no flush is in progress.
  assign advance_s     = bus.rdy & ~bus.rollback;
  assign clr_s         = bus.rdy & bus.rollback;
  assign bus.src_ready = ready_s;

  // Per-source ready/occupancy decode from registered counts, push/pop strobes.
  always_comb begin
    ready_s    = '0;
    nonempty_s = '0;
    push_s     = '0;
    pop_s      = '0;
    for (int i = 0; i < NSRC; i++) begin
      ready_s[i]    = (count_s[i] < 2'd2);
      nonempty_s[i] = (count_s[i] != 2'd0);
      push_s[i]     = bus.src_valid[i] & ready_s[i] & advance_s;
      pop_s[i]      = grant_s & (int'(win_s) == i) & advance_s;
    end
  end

  // Round-robin search: first non-empty FIFO at or after ptr wins.
  always_comb begin
    int idx;
    idx        = 0;
    grant_s    = 1'b0;
    win_s      = 2'd0;
    win_head_s = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NSRC) begin
        idx = idx - NSRC;
      end else begin
        idx = idx;
      end
      if (!grant_s && nonempty_s[idx]) begin
        grant_s    = 1'b1;
        win_s      = 2'(idx);
        win_head_s = head_s[idx];
      end else begin
        grant_s = grant_s;
      end
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    cdb_fifo2 #(.W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_s),
      .push  (push_s[i]),
      .pop   (pop_s[i]),
      .din   ({bus.src_result[32*i +: 32], bus.src_tag[TAG_W*i +: TAG_W]}),
      .dout  (head_s[i]),
      .count (count_s[i])
    );
  end

  // Broadcast registers and round-robin pointer; frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r          <= 2'd0;
      bus.cdb_valid  <= 1'b0;
      bus.cdb_result <= 32'd0;
      bus.cdb_tag    <= '0;
      bus.cdb_src    <= SRC_ALU;
    end else if (bus.rdy) begin
      if (bus.rollback) begin
        bus.cdb_valid <= 1'b0;
      end else if (grant_s) begin
        bus.cdb_valid  <= 1'b1;
        bus.cdb_result <= win_head_s[EW-1 -: 32];
        bus.cdb_tag    <= win_head_s[TAG_W-1:0];
        bus.cdb_src    <= win_s;
        ptr_r          <= rr_next(win_s, NSRC);
      end else begin
        bus.cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// every broadcast; a negedge monitor compares the DUT against it.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = CDB_NSRC;
  localparam int TW = ROB_TAG_W;
  localparam int BW = 32 + TW + 2;

  typedef struct {
    logic [31:0]   res;
    logic [TW-1:0] tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NSRC(N), .TAG_W(TW)) bus ();
  cdb_arbiter #(.NSRC(N), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  ent_t          mq [N][$];
  logic [BW-1:0] sb [$];
  int            m_ptr;
  logic          m_valid;
  logic          m_fresh;
  logic [BW-1:0] m_last;
  bit            sat = 1'b0;
  int            zrun [N];
  int            zmax [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-source queues, round-robin from ptr, pop before push.
  initial begin : model
    bit   acc [N];
    int   win;
    ent_t e;
    m_ptr = 0; m_valid = 1'b0; m_fresh = 1'b0; m_last = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        sb.delete();
        m_ptr = 0; m_valid = 1'b0; m_fresh = 1'b0; m_last = '0;
      end else begin
        m_fresh = 1'b0;
        if (bus.rdy) begin
          if (bus.rollback) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 1'b0;
          end else begin
            for (int i = 0; i < N; i++) acc[i] = bus.src_valid[i] && (mq[i].size() < 2);
            win = -1;
            for (int k = 0; k < N; k++) begin
              int j;
              j = (m_ptr + k) % N;
              if (win < 0 && mq[j].size() > 0) win = j;
            end
            if (win >= 0) begin
              e = mq[win].pop_front();
              m_last  = {e.res, e.tag, 2'(win)};
              sb.push_back(m_last);
              m_valid = 1'b1;
              m_fresh = 1'b1;
              m_ptr   = (win + 1) % N;
            end else begin
              m_valid = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
              if (acc[i]) begin
                e.res = bus.src_result[32*i +: 32];
                e.tag = bus.src_tag[TW*i +: TW];
                mq[i].push_back(e);
              end
            end
          end
        end
      end
    end
  end

  // Monitor: compare ready, valid and broadcast/held payload on each negedge.
  initial begin : monitor
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) begin zrun[i] = 0; zmax[i] = 0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) er[i] = (mq[i].size() < 2);
        chk("src_ready", 64'(bus.src_ready), 64'(er));
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
        if (m_fresh) begin
          chk("broadcast", 64'({bus.cdb_result, bus.cdb_tag, bus.cdb_src}), 64'(sb.pop_front()));
        end else begin
          chk("cdb_hold", 64'({bus.cdb_result, bus.cdb_tag, bus.cdb_src}), 64'(m_last));
        end
        if (sat) begin
          for (int i = 0; i < N; i++) begin
            if (!bus.src_ready[i]) zrun[i]++; else zrun[i] = 0;
            if (zrun[i] > zmax[i]) zmax[i] = zrun[i];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input int i, input logic [31:0] r, input logic [TW-1:0] t);
    bus.src_valid[i]           = 1'b1;
    bus.src_result[32*i +: 32] = r;
    bus.src_tag[TW*i +: TW]    = t;
  endtask

  task automatic offer_all(input int c);
    for (int i = 0; i < N; i++) offer(i, 32'h1000 * (i + 1) + c, TW'(c + i));
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_valid"},  64'(bus.cdb_valid),  64'd0);
    chk({tag, "_result"}, 64'(bus.cdb_result), 64'd0);
    chk({tag, "_tag"},    64'(bus.cdb_tag),    64'd0);
    chk({tag, "_src"},    64'(bus.cdb_src),    64'd0);
    chk({tag, "_ready"},  64'(bus.src_ready),  64'(3'b111));
  endtask

  initial begin : stim
    bus.src_valid = '0; bus.src_result = '0; bus.src_tag = '0;
    bus.rdy = 1'b1; bus.rollback = 1'b0;
    #1 rst = 1'b0;
    #1 rst_checks("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Single ALU offer, two-cycle latency.
    tick();
    offer(0, 32'h11, 4'd3);
    tick();
    bus.src_valid = '0;
    repeat (4) tick();

    // All sources saturating.
    sat = 1'b1;
    for (int c = 0; c < 12; c++) begin offer_all(c); tick(); end
    sat = 1'b0;
    bus.src_valid = '0;
    repeat (6) tick();
    for (int i = 0; i < N; i++) chk("ready_low_run", 64'(zmax[i] <= 3), 64'd1);

    // LSB burst of three while ALU offers every cycle.
    for (int c = 0; c < 7; c++) begin
      offer(0, 32'h2000 + c, TW'(c));
      if (c < 3) offer(1, 32'hA + c, TW'(c + 8)); else bus.src_valid[1] = 1'b0;
      tick();
    end
    bus.src_valid = '0;
    repeat (8) tick();

    // Rollback with loaded FIFOs and a same-cycle ALU offer.
    for (int c = 0; c < 2; c++) begin offer_all(c + 20); tick(); end
    bus.src_valid = '0;
    offer(0, 32'hDEAD, 4'd9);
    bus.rollback = 1'b1;
    tick();
    bus.rollback = 1'b0;
    bus.src_valid = '0;
    repeat (5) tick();

    // rdy low for three cycles mid-stream.
    for (int c = 0; c < 4; c++) begin offer_all(c + 30); tick(); end
    bus.rdy = 1'b0;
    repeat (3) tick();
    bus.rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin offer_all(c + 40); tick(); end
    bus.src_valid = '0;
    repeat (6) tick();

    // Asynchronous reset pulse between edges with entries buffered.
    for (int c = 0; c < 2; c++) begin offer_all(c + 50); tick(); end
    rst = 1'b0;
    #1 rst_checks("rst_pulse");
    #1 rst = 1'b1;
    bus.src_valid = '0;
    offer(1, 32'h55, 4'd7);
    tick();
    bus.src_valid = '0;
    repeat (4) tick();

    // Randomized traffic with occasional stalls and flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) offer(i, $urandom, TW'($urandom));
        else bus.src_valid[i] = 1'b0;
      end
      bus.rdy      = ($urandom_range(0, 7) != 0);
      bus.rollback = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.src_valid = '0; bus.rdy = 1'b1; bus.rollback = 1'b0;
    repeat (8) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
